// File: rtl/gray_counter_ud_if.sv
// rtl/gray_counter_ud_if.sv - control/status bundle of the up/down Gray counter
// The err signal exists only when GRAY_ERR_CHK_EN is defined.
interface gray_counter_ud_if #(
  parameter int WIDTH = 17
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] gray_c;
  logic             zero;
  logic             wrap;
`ifdef GRAY_ERR_CHK_EN
  logic             err;
`endif

  modport master (
    output en, dir, load, load_val,
    input  bin_c, gray_c, zero, wrap
`ifdef GRAY_ERR_CHK_EN
    , input err
`endif
  );

  modport slave (
    input  en, dir, load, load_val,
    output bin_c, gray_c, zero, wrap
`ifdef GRAY_ERR_CHK_EN
    , output err
`endif
  );
endinterface

// File: rtl/gray_counter_ud.sv
// rtl/gray_counter_ud.sv - parametrised up/down Gray counter with load, zero and wrap flags
// Optional sticky multi-bit-step checker enabled by GRAY_ERR_CHK_EN.
module gray_counter_ud #(
  parameter int          WIDTH    = 17,
  parameter int unsigned RST_VAL  = 0,
  parameter int          LOAD_FMT = 0
) (
  input logic               clk,
  input logic               rst,
  gray_counter_ud_if.slave  s_if
);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_zero;
  logic             r_wrap;

  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin : gray_decode
    logic w_acc;
    w_acc = 1'b0;
    w_dec = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ s_if.load_val[i];
      w_dec[i] = w_acc;
    end
  end

  assign w_load_bin = (LOAD_FMT != 0) ? w_dec : s_if.load_val;

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (s_if.load) begin
      w_next_bin = w_load_bin;
    end else if (s_if.en) begin
      if (s_if.dir) begin
        w_next_bin  = r_bin + ONE;
        w_next_wrap = (r_bin == ALL1);
      end else begin
        w_next_bin  = r_bin - ONE;
        w_next_wrap = (r_bin == '0);
      end
    end
  end

  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  // Binary and Gray share one register stage so they are never skewed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_zero <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_zero <= (w_next_bin == '0);
      r_wrap <= w_next_wrap;
    end
  end

  assign s_if.bin_c  = r_bin;
  assign s_if.gray_c = r_gray;
  assign s_if.zero   = r_zero;
  assign s_if.wrap   = r_wrap;

`ifdef GRAY_ERR_CHK_EN
  logic             r_err;
  logic [WIDTH-1:0] w_gdiff;

  // More than one bit set in the step difference means a non-Gray transition.
  assign w_gdiff = w_next_gray ^ r_gray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (!s_if.load && ((w_gdiff & (w_gdiff - ONE)) != '0)) begin
      r_err <= 1'b1;
    end
  end

  assign s_if.err = r_err;

  a_gray_single_step: assert property (@(posedge clk) disable iff (!rst)
    (s_if.en && !s_if.load) |=> ($countones(r_gray ^ $past(r_gray)) == 1));
`endif
endmodule
